// File: rtl/system_nios2_qsys_0_oci_dct_pkg.sv
// system_nios2_qsys_0_oci_dct_pkg: DCT packer widths and drain controller states.
package system_nios2_qsys_0_oci_dct_pkg;
    localparam int DCT_SLOTS  = 10;
    localparam int DCT_CODE_W = 3;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;
    typedef enum logic [1:0] {RUN, DRAIN, ENDED} dct_state_e;
endpackage

// File: rtl/system_nios2_qsys_0_oci_dct_frame_reg.sv
// system_nios2_qsys_0_oci_dct_frame_reg: one-entry valid/ready register holding the outgoing DCT frame.
module system_nios2_qsys_0_oci_dct_frame_reg
    import system_nios2_qsys_0_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_data,
    input  logic [DCT_CNT_W-1:0] load_count,
    input  logic                 frm_ready,
    output logic                 free,
    output logic                 frm_valid,
    output logic [DCT_BUF_W-1:0] frm_data,
    output logic [DCT_CNT_W-1:0] frm_count
);
    logic                 valid_q, valid_d;
    logic [DCT_BUF_W-1:0] data_q, data_d;
    logic [DCT_CNT_W-1:0] count_q, count_d;
    always_comb begin
        free    = !valid_q || frm_ready;
        valid_d = load || (valid_q && !frm_ready);
        data_d  = load ? load_data : data_q;
        count_d = load ? load_count : count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end
    assign frm_valid = valid_q;
    assign frm_data  = data_q;
    assign frm_count = count_q;
endmodule

// File: rtl/system_nios2_qsys_0_oci_dct_packer.sv
// system_nios2_qsys_0_oci_dct_packer: packs 3-bit trace codes into 10-slot DCT frames and runs the end-of-test drain.
// Define OCI_DCT_TIMEOUT_EN to auto-flush a partial buffer after TIMEOUT_CYCLES idle cycles.
module system_nios2_qsys_0_oci_dct_packer
    import system_nios2_qsys_0_oci_dct_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trc_valid,
    input  logic [DCT_CODE_W-1:0] trc_code,
    output logic                  trc_ready,
    input  logic                  flush,
    input  logic                  test_ending,
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [DCT_BUF_W-1:0]  frm_data,
    output logic [DCT_CNT_W-1:0]  frm_count,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  test_has_ended
);
    localparam logic [DCT_CNT_W-1:0] FULL = DCT_CNT_W'(DCT_SLOTS);
    dct_state_e           state_q, state_d;
    logic [DCT_BUF_W-1:0] dct_buffer_q, dct_buffer_d, base_buf;
    logic [DCT_CNT_W-1:0] dct_count_q, dct_count_d, base_cnt;
    logic                 flush_pend_q, flush_pend_d, ended_q, ended_d;
    logic                 slot_free, accept, emit, timeout;

    system_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (emit),
        .load_data  (dct_buffer_q),
        .load_count (dct_count_q),
        .frm_ready  (frm_ready),
        .free       (slot_free),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_count  (frm_count)
    );

    // An emit empties the accumulator first, so a same-cycle accept lands in slot 0.
    always_comb begin
        trc_ready    = (dct_count_q != FULL || slot_free) && !flush_pend_q && state_q == RUN && !reset;
        accept       = trc_valid && trc_ready;
        emit         = slot_free && (dct_count_q == FULL || (flush_pend_q && dct_count_q != '0));
        base_buf     = emit ? '0 : dct_buffer_q;
        base_cnt     = emit ? '0 : dct_count_q;
        dct_buffer_d = accept ? base_buf | (DCT_BUF_W'(trc_code) << (DCT_CODE_W * base_cnt)) : base_buf;
        dct_count_d  = accept ? base_cnt + 1'b1 : base_cnt;
        flush_pend_d = (flush_pend_q && !slot_free) || (state_q == RUN && (flush || test_ending)) || timeout;
        state_d      = state_q == RUN && test_ending ? DRAIN
                     : state_q == DRAIN && dct_count_q == '0 && !flush_pend_q && !frm_valid ? ENDED
                     : state_q;
        ended_d      = state_d == ENDED;
    end

`ifdef OCI_DCT_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    logic [IDLE_W-1:0] idle_q, idle_d;
    always_comb begin
        timeout = idle_q == IDLE_MAX && !flush_pend_q;
        idle_d  = accept || emit || dct_count_q == '0 ? '0 : idle_q + IDLE_W'(idle_q != IDLE_MAX);
    end
    always_ff @(posedge clk) begin
        idle_q <= reset ? '0 : idle_d;
    end
`else
    logic unused_timeout_cycles;
    assign timeout = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            dct_buffer_q <= '0;
            dct_count_q  <= '0;
            flush_pend_q <= 1'b0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dct_buffer_q <= dct_buffer_d;
            dct_count_q  <= dct_count_d;
            flush_pend_q <= flush_pend_d;
            ended_q      <= ended_d;
        end
    end

    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign test_has_ended = ended_q;
endmodule

// File: tb/tb_system_nios2_qsys_0_oci_dct_packer.sv
// tb_system_nios2_qsys_0_oci_dct_packer: scoreboard bench for the DCT packer; frames are predicted from a list of accepted codes.
// Honours OCI_DCT_TIMEOUT_EN when the design is built with it.
module tb_system_nios2_qsys_0_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset, trc_valid, flush, test_ending, frm_ready;
    logic [2:0]  trc_code;
    logic        trc_ready, frm_valid, test_has_ended;
    logic [29:0] frm_data, dct_buffer;
    logic [3:0]  frm_count, dct_count;

    int          n_chk = 0, n_fail = 0;
    logic [29:0] exp_d[$];
    logic [3:0]  exp_c[$];
    logic [2:0]  acc_codes[$];
    bit          draining = 0;

    logic [29:0] m_d, prev_d;
    logic [3:0]  m_c, prev_c;
    bit          prev_hold = 0;

    always #5 clk = ~clk;

    system_nios2_qsys_0_oci_dct_packer #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .trc_valid      (trc_valid),
        .trc_code       (trc_code),
        .trc_ready      (trc_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_data       (frm_data),
        .frm_count      (frm_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Frame value is the codes read as base-8 digits, first code least significant.
    function automatic void push_frame();
        logic [29:0] d = '0;
        longint      w = 1;
        foreach (acc_codes[k]) begin
            d = d + 30'(longint'(acc_codes[k]) * w);
            w = w * 8;
        end
        exp_d.push_back(d);
        exp_c.push_back(4'(acc_codes.size()));
        acc_codes.delete();
    endfunction

    task automatic tick(input bit v, input logic [2:0] c, input bit fl, input bit te, output bit acc);
        @(negedge clk);
        trc_valid = v; trc_code = c; flush = fl; test_ending = te;
        #1;
        acc = v && trc_ready && !reset;
        if (acc) begin
            acc_codes.push_back(c);
            if (acc_codes.size() == 10) push_frame();
        end
        if (!reset && !draining && (fl || te)) begin
            if (acc_codes.size() > 0) push_frame();
            if (te) draining = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) tick(0, 3'd0, 0, 0, a);
    endtask

    task automatic send(input logic [2:0] c);
        bit a = 0;
        for (int i = 0; i < 40 && !a; i++) tick(1, c, 0, 0, a);
        chk("send_accepted", 32'(a), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; trc_valid = 0; flush = 0; test_ending = 0;
        @(posedge clk);
        #1;
        exp_d.delete(); exp_c.delete(); acc_codes.delete(); draining = 0;
        chk("rst_frm_valid", 32'(frm_valid), 0);
        chk("rst_frm_data", 32'(frm_data), 0);
        chk("rst_frm_count", 32'(frm_count), 0);
        chk("rst_dct_buffer", 32'(dct_buffer), 0);
        chk("rst_dct_count", 32'(dct_count), 0);
        chk("rst_test_has_ended", 32'(test_has_ended), 0);
        chk("rst_trc_ready", 32'(trc_ready), 0);
        @(negedge clk);
        reset = 0;
    endtask

    initial forever begin
        @(negedge clk);
        #3;
        if (reset) prev_hold = 0;
        else begin
            if (prev_hold) begin
                chk("hold_data_stable", 32'(frm_data), 32'(prev_d));
                chk("hold_count_stable", 32'(frm_count), 32'(prev_c));
            end
            if (frm_valid && frm_ready) begin
                if (exp_d.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_frame: got data 0x%0h count %0d, required no frame", frm_data, frm_count);
                end else begin
                    m_d = exp_d.pop_front();
                    m_c = exp_c.pop_front();
                    chk("frame_data", 32'(frm_data), 32'(m_d));
                    chk("frame_count", 32'(frm_count), 32'(m_c));
                end
            end
            prev_hold = frm_valid && !frm_ready;
            prev_d = frm_data;
            prev_c = frm_count;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, fl, v, got;
        int na, since;
        logic [2:0] ten[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
        reset = 1; trc_valid = 0; trc_code = 0; flush = 0; test_ending = 0; frm_ready = 1;
        do_reset();

        foreach (ten[i]) send(ten[i]);
        chk("ten_count_full", 32'(dct_count), 10);
        idle(1);
        chk("ten_frm_valid", 32'(frm_valid), 1);
        chk("ten_frm_data", 32'(frm_data), 32'(30'o3217654321));
        chk("ten_frm_count", 32'(frm_count), 10);
        chk("ten_dct_count", 32'(dct_count), 0);
        idle(2);

        frm_ready = 0;
        na = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1, 3'($urandom_range(7, 0)), 0, 0, a);
            na += int'(a);
        end
        chk("bp_accepts", 32'(na), 20);
        chk("bp_trc_ready", 32'(trc_ready), 0);
        frm_ready = 1;
        tick(1, 3'd5, 0, 0, a);
        chk("bp_21st_accept", 32'(a), 1);
        chk("bp_21st_count", 32'(dct_count), 1);
        tick(0, 3'd0, 1, 0, a);
        idle(5);

        send(3'd5); send(3'd6); send(3'd7);
        chk("flush_live_buffer", 32'(dct_buffer), 32'(30'o765));
        chk("flush_live_count", 32'(dct_count), 3);
        tick(0, 3'd0, 1, 0, a);
        chk("flush_pending_no_frame", 32'(frm_valid), 0);
        chk("flush_blocks_trc", 32'(trc_ready), 0);
        idle(1);
        chk("flush_frm_valid", 32'(frm_valid), 1);
        chk("flush_frm_data", 32'(frm_data), 32'(30'o765));
        chk("flush_frm_count", 32'(frm_count), 3);
        idle(2);
        tick(0, 3'd0, 1, 0, a);
        idle(4);
        chk("empty_flush_no_frame", 32'(frm_valid), 0);

        send(3'd3); send(3'd4);
`ifdef OCI_DCT_TIMEOUT_EN
        push_frame();
        idle(9);
        chk("timeout_not_yet", 32'(frm_valid), 0);
        idle(1);
        chk("timeout_frm_valid", 32'(frm_valid), 1);
        chk("timeout_frm_count", 32'(frm_count), 2);
        idle(3);
`else
        idle(20);
        chk("no_timeout_count", 32'(dct_count), 2);
        chk("no_timeout_frm_valid", 32'(frm_valid), 0);
        tick(0, 3'd0, 1, 0, a);
        idle(4);
`endif

        since = 0;
        for (int i = 0; i < 400; i++) begin
            frm_ready = ($urandom_range(3, 0) != 0);
            fl = ($urandom_range(19, 0) == 0);
            v = !fl && (since >= 4 || $urandom_range(3, 0) != 0);
            tick(v, 3'($urandom_range(7, 0)), fl, 0, a);
            since = a ? 0 : since + 1;
        end
        frm_ready = 1;
        tick(0, 3'd0, 1, 0, a);
        idle(5);
        chk("random_drained", 32'(exp_d.size()), 0);

        send(3'd1); send(3'd2); send(3'd3); send(3'd4);
        tick(0, 3'd0, 0, 1, a);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            idle(1);
            got = test_has_ended;
        end
        chk("eot_ended", 32'(got), 1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 3'($urandom_range(7, 0)), 1, 1, a);
            chk("eot_no_accept", 32'(a), 0);
            chk("eot_trc_ready", 32'(trc_ready), 0);
            chk("eot_sticky", 32'(test_has_ended), 1);
        end
        chk("eot_drained", 32'(exp_d.size()), 0);

        do_reset();
        frm_ready = 0;
        foreach (ten[i]) send(ten[i]);
        idle(2);
        chk("midframe_held", 32'(frm_valid), 1);
        do_reset();
        frm_ready = 1;
        send(3'd6);
        tick(0, 3'd0, 1, 0, a);
        idle(4);
        chk("final_queue_empty", 32'(exp_d.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
